// File: rtl/seg7_scan_controller.sv
// Time-multiplexed seven-segment scan controller: frame-synchronous shadow value,
// per-digit anode strobing with blanking and leading-zero suppression.
module seg7_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_blank_mask,
    input  logic                  i_lz_suppress,
    output logic [3:0]            o_nibble,
    output logic [DIGITS-1:0]     o_anode
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int DIG_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [DIG_W-1:0]     digit, digit_nx;
    logic [4*DIGITS-1:0]  shadow, shadow_nx;
    logic [4*DIGITS-1:0]  pend_val, pend_val_nx;
    logic                 pend, pend_nx;

    logic                 commit_edge;
    logic [DIGITS-1:0]    lz_vec;
    logic                 upper_zero;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            digit    <= '0;
            shadow   <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            digit    <= digit_nx;
            shadow   <= shadow_nx;
            pend_val <= pend_val_nx;
            pend     <= pend_nx;
        end
    end

    // A pending value only moves to the shadow on a commit edge, so a frame never mixes values.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        digit_nx    = digit;
        shadow_nx   = shadow;
        pend_val_nx = pend_val;
        pend_nx     = pend;

        commit_edge = (state == IDLE) ||
                      ((state == SCAN) && (cnt == CNT_LAST) && (digit == DIG_LAST));

        if (pend && commit_edge) begin
            shadow_nx = pend_val;
            pend_nx   = 1'b0;
        end else if (i_valid && !pend) begin
            pend_val_nx = i_value;
            pend_nx     = 1'b1;
        end

        if (state == IDLE) begin
            if (i_enable) begin
                state_nx = SCAN;
                cnt_nx   = '0;
                digit_nx = '0;
            end
        end else begin
            if (!i_enable) begin
                state_nx = IDLE;
                cnt_nx   = '0;
                digit_nx = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_nx   = '0;
                digit_nx = (digit == DIG_LAST) ? '0 : digit + DIG_W'(1);
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    // Digit k is a leading zero when it and every more significant nibble are zero; digit 0 never is.
    always_comb begin
        lz_vec     = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (shadow[4*k +: 4] == 4'h0);
            lz_vec[k]  = i_lz_suppress && upper_zero;
        end
    end

    always_comb begin
        o_nibble = 4'h0;
        o_anode  = '1;
        if (state == SCAN) begin
            o_nibble = shadow[{digit, 2'b00} +: 4];
            if (!i_blank_mask[digit] && !lz_vec[digit]) begin
                o_anode = ~(DIGITS'(1) << digit);
            end
        end
    end

    assign o_ready = !pend;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized and directed bench for seg7_scan_controller against a time-based display model.
module tb_seg7_scan_controller;

    logic        clk = 1'b0;
    logic        i_reset, i_enable, i_valid, i_lz_suppress;
    logic [15:0] i_value;
    logic [3:0]  i_blank_mask;
    logic        o_ready;
    logic [3:0]  o_nibble;
    logic [3:0]  o_anode;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: scan position is elapsed cycles since scan start.
    bit          m_scan;
    int          m_t;
    logic [15:0] m_shadow, m_pval;
    bit          m_pend, m_acc;

    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] exp_old [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] exp_new [4] = '{4'hD, 4'hC, 4'hB, 4'hA};

    seg7_scan_controller #(.DIGITS(4), .PRESCALE(4)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_value      (i_value),
        .i_blank_mask (i_blank_mask),
        .i_lz_suppress(i_lz_suppress),
        .o_nibble     (o_nibble),
        .o_anode      (o_anode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_t = 0; m_shadow = 0; m_pval = 0; m_pend = 0; m_acc = 0;
    endtask

    task automatic model_edge();
        bit boundary;
        boundary = m_scan && (m_t % 16 == 15);
        m_acc = 0;
        if (m_pend && (!m_scan || boundary)) begin
            m_shadow = m_pval;
            m_pend   = 0;
        end else if (i_valid && !m_pend) begin
            m_pval = i_value;
            m_pend = 1;
            m_acc  = 1;
        end
        if (!m_scan) begin
            if (i_enable) begin
                m_scan = 1;
                m_t    = 0;
            end
        end else if (!i_enable) begin
            m_scan = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic model_out(output logic [3:0] an, output logic [3:0] nib);
        int d;
        logic [15:0] upper;
        an  = 4'hF;
        nib = 4'h0;
        if (m_scan) begin
            d     = (m_t / 4) % 4;
            upper = m_shadow >> (4 * d);
            nib   = upper[3:0];
            if (!(i_blank_mask[d] || (i_lz_suppress && d >= 1 && upper == 16'h0)))
                an = ~(4'b0001 << d);
        end
    endtask

    task automatic cycle();
        logic [3:0] ea, en;
        @(negedge clk);
        model_out(ea, en);
        check("anode", {28'h0, o_anode}, {28'h0, ea});
        check("nibble", {28'h0, o_nibble}, {28'h0, en});
        check("ready", {31'h0, o_ready}, {31'h0, !m_pend});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_idle(input logic [15:0] v);
        int n;
        i_enable = 0;
        n = 0;
        while (m_scan && n < 4) begin cycle(); n++; end
        i_valid = 1;
        i_value = v;
        n = 0;
        while (!(!m_pend && m_shadow == v && !i_valid) && n < 10) begin
            cycle();
            if (m_acc) i_valid = 0;
            n++;
        end
        i_valid = 0;
        check("load_ready", {31'h0, o_ready}, 32'h1);
    endtask

    initial begin
        int n;
        i_reset = 1; i_enable = 0; i_valid = 0; i_value = 0;
        i_blank_mask = 0; i_lz_suppress = 0;
        model_reset();
        #1;
        check("rst_anode", {28'h0, o_anode}, 32'hF);
        check("rst_nibble", {28'h0, o_nibble}, 32'h0);
        check("rst_ready", {31'h0, o_ready}, 32'h1);
        #1 i_reset = 0;
        @(posedge clk); #1;

        // Scan order
        load_idle(16'h1234);
        i_enable = 1;
        cycle();
        for (int i = 0; i < 32; i++) begin
            check("order_an", {28'h0, o_anode}, {28'h0, exp_an[(i / 4) % 4]});
            check("order_nib", {28'h0, o_nibble}, {28'h0, exp_old[(i / 4) % 4]});
            cycle();
        end

        // Tear-free update
        n = 0;
        while (((m_t / 4) % 4 != 1) && n < 20) begin cycle(); n++; end
        i_valid = 1; i_value = 16'hABCD;
        cycle();
        i_valid = 0;
        check("tf_ready0", {31'h0, o_ready}, 32'h0);
        n = 0;
        while (!o_ready && n < 20) begin cycle(); n++; end
        check("tf_ready1", {31'h0, o_ready}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("tf_an", {28'h0, o_anode}, {28'h0, exp_an[i / 4]});
            check("tf_nib", {28'h0, o_nibble}, {28'h0, exp_new[i / 4]});
            cycle();
        end

        // Back-pressure
        i_valid = 1; i_value = 16'h1111;
        cycle();
        i_value = 16'h5555;
        check("bp_ready0", {31'h0, o_ready}, 32'h0);
        n = 0;
        while (!o_ready && n < 20) begin cycle(); n++; end
        check("bp_ready1", {31'h0, o_ready}, 32'h1);
        cycle();
        i_valid = 0;
        check("bp_accept", {31'h0, o_ready}, 32'h0);

        // Acceptance on a frame-boundary edge
        n = 0;
        while (!o_ready && n < 20) begin cycle(); n++; end
        n = 0;
        while ((m_t % 16 != 15) && n < 20) begin cycle(); n++; end
        i_valid = 1; i_value = 16'h9999;
        cycle();
        i_valid = 0;
        check("bnd_ready0", {31'h0, o_ready}, 32'h0);
        n = 0;
        while (!o_ready && n < 40) begin cycle(); n++; end
        check("bnd_latency", n, 16);

        // Reset mid-scan with a pending value
        n = 0;
        while ((m_t % 16 >= 12) && n < 20) begin cycle(); n++; end
        i_valid = 1; i_value = 16'h7777;
        cycle();
        i_valid = 0;
        check("rst_pend", {31'h0, o_ready}, 32'h0);
        i_reset = 1;
        #1;
        check("mid_rst_anode", {28'h0, o_anode}, 32'hF);
        check("mid_rst_nibble", {28'h0, o_nibble}, 32'h0);
        check("mid_rst_ready", {31'h0, o_ready}, 32'h1);
        model_reset();
        i_enable = 0;
        #1 i_reset = 0;
        cycle();
        check("post_rst_idle", {28'h0, o_anode}, 32'hF);

        // Blanking and leading-zero suppression
        load_idle(16'h0042);
        i_blank_mask = 4'b0001; i_lz_suppress = 1; i_enable = 1;
        cycle();
        for (int i = 0; i < 16; i++) begin
            case (i / 4)
                0: begin check("bl_an0", {28'h0, o_anode}, 32'hF); check("bl_nib0", {28'h0, o_nibble}, 32'h2); end
                1: begin check("bl_an1", {28'h0, o_anode}, 32'hD); check("bl_nib1", {28'h0, o_nibble}, 32'h4); end
                default: check("bl_lz", {28'h0, o_anode}, 32'hF);
            endcase
            cycle();
        end
        load_idle(16'h0000);
        i_blank_mask = 4'b0000; i_enable = 1;
        cycle();
        for (int i = 0; i < 16; i++) begin
            check("zero_an", {28'h0, o_anode}, (i < 4) ? 32'hE : 32'hF);
            check("zero_nib", {28'h0, o_nibble}, 32'h0);
            cycle();
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
            if ($urandom_range(0, 7) == 0) i_blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) i_lz_suppress = ~i_lz_suppress;
            if (!i_valid && $urandom_range(0, 5) == 0) begin
                i_valid = 1;
                i_value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            end
            cycle();
            if (m_acc) i_valid = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
